// File: rtl/codificador_16_canales.sv
// Registered 16-channel round-robin request encoder.
// Buffers request pulses per channel and grants one code per handshake.
module codificador_16_canales #(
    parameter int CANALES = 16,
    parameter int ANCHO   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CANALES-1:0] req,
    input  logic               ready,
    output logic [ANCHO-1:0]   S,
    output logic [CANALES-1:0] Y,
    output logic               valid,
    output logic [CANALES-1:0] pend,
    output logic               overflow
);

    localparam logic [CANALES-1:0] UNO = CANALES'(1);

    logic [ANCHO-1:0]   ptr;
    logic [CANALES-1:0] clr;
    logic [CANALES-1:0] cand;
    logic [ANCHO-1:0]   idx;
    logic [ANCHO-1:0]   pos;
    logic               hallado;
    logic               carga;

    // Accepted channel is removed from both the pending set and the search
    always_comb begin
        clr = '0;
        if (valid && ready) begin
            clr = UNO << S;
        end
        cand  = pend & ~clr;
        carga = !valid || ready;
    end

    // Round-robin search: first candidate at or after ptr, wrapping at 15
    always_comb begin
        hallado = 1'b0;
        idx     = ptr;
        pos     = ptr;
        for (int k = 0; k < CANALES; k++) begin
            pos = ptr + ANCHO'(k);
            if (!hallado && cand[pos]) begin
                hallado = 1'b1;
                idx     = pos;
            end
        end
    end

    // Pending set, sticky overflow and the registered output grant
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            overflow <= 1'b0;
            S        <= '0;
            Y        <= '0;
            valid    <= 1'b0;
            ptr      <= '0;
        end else begin
            pend <= cand | req;
            if (|(req & cand)) begin
                overflow <= 1'b1;
            end
            if (carga) begin
                if (hallado) begin
                    S     <= idx;
                    Y     <= UNO << idx;
                    valid <= 1'b1;
                    ptr   <= idx + ANCHO'(1);
                end else begin
                    Y     <= '0;
                    valid <= 1'b0;
                end
            end
        end
    end

endmodule
